// File: rtl/ram_sp_arb_pkg.sv
// rtl/ram_sp_arb_pkg.sv - shared constants for the single-port RAM arbiter
//
// Purpose: FSM state encodings, requester count and op encoding used by
//          ram_sp_arbiter and rr_arb2.
// Optional feature macro (consumed by rr_arb2): RAM_SP_ARB_FIXED_PRIO_EN
package ram_sp_arb_pkg;

    localparam int NUM_REQ = 2;

    // Op encoding as presented on req_we.
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Controller FSM states.
    typedef logic [2:0] state_t;
    localparam state_t IDLE     = 3'd0;
    localparam state_t WRITE    = 3'd1;
    localparam state_t READ     = 3'd2;
    localparam state_t READ_CAP = 3'd3;
    localparam state_t RESP     = 3'd4;

    // Requester that is not the given one (two-way arbitration only).
    function automatic logic other_req(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way grant selection
//
// Purpose: pick one of two requesters. A single request is granted directly;
//          a tie goes to the requester that was not granted last, or, when
//          RAM_SP_ARB_FIXED_PRIO_EN is defined, always to requester 0.
// Ports:
//   req       in  NUM_REQ  request vector, bit i = requester i
//   last_gnt  in  1        id of the most recently granted requester
//   gnt_valid out 1        at least one request present
//   gnt_id    out 1        id of the selected requester
// Macro: RAM_SP_ARB_FIXED_PRIO_EN
module rr_arb2
    import ram_sp_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_gnt,
    output logic               gnt_valid,
    output logic               gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11: begin
`ifdef RAM_SP_ARB_FIXED_PRIO_EN
                // Requester 0 always wins a tie; requester 1 may starve.
                gnt_id = 1'b0;
`else
                gnt_id = other_req(last_gnt);
`endif
            end
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// rtl/ram_sp_arbiter.sv - two-requester controller for one single-port RAM
//
// Purpose: serialises word reads/writes from two clients onto a single-port
//          RAM with a tri-state data bus, sequencing cs/we/oe and owning the
//          bus turnaround. Grants are round-robin (fixed priority with
//          RAM_SP_ARB_FIXED_PRIO_EN defined).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[1:0]          per-requester request
//   req_we[1:0]       per-requester op, 1 = write, 0 = read
//   req_addr          requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata         requester i write data at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack[1:0]          one-cycle completion pulse to the granted requester
//   rdata             registered read data, valid while ack is high for a read
//   ram_addr, ram_cs, ram_we, ram_oe   RAM control pins
//   ram_data          shared RAM data bus, driven here only in WRITE
// Macro: RAM_SP_ARB_FIXED_PRIO_EN
module ram_sp_arbiter
    import ram_sp_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic                      ram_cs,
    output logic                      ram_we,
    output logic                      ram_oe,
    inout  wire  [DATA_WIDTH-1:0]     ram_data
);

    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
        $error("ram_sp_arbiter: DEPTH must equal 2**ADDR_WIDTH");
    end

    state_t                  state_q, state_d;
    logic                    gnt_q, gnt_d;
    logic                    op_q, op_d;
    logic                    last_gnt_q, last_gnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    arb_valid;
    logic                    arb_id;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    rr_arb2 u_arb (
        .req       (req),
        .last_gnt  (last_gnt_q),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    assign sel_addr  = arb_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = arb_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                              : req_wdata[DATA_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        op_d       = op_q;
        last_gnt_d = last_gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                // Requests that arrived while busy are still held high, so
                // they are simply seen here on the next IDLE cycle.
                if (arb_valid) begin
                    gnt_d      = arb_id;
                    op_d       = req_we[arb_id];
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    last_gnt_d = arb_id;
                    state_d    = (req_we[arb_id] == OP_WRITE) ? WRITE : READ;
                end
            end
            WRITE:    state_d = IDLE;
            READ:     state_d = READ_CAP;
            READ_CAP: begin
                // The RAM is driving the word it registered at the end of READ.
                rdata_d = ram_data;
                state_d = RESP;
            end
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            op_q       <= OP_READ;
            last_gnt_q <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            op_q       <= op_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    // RAM pins and ack decode straight from the state register, so a reset
    // edge releases every control (and the bus) from the following cycle.
    always_comb begin
        ram_cs = 1'b0;
        ram_we = 1'b0;
        ram_oe = 1'b0;
        ack    = '0;
        case (state_q)
            WRITE: begin
                ram_cs     = 1'b1;
                ram_we     = 1'b1;
                ack[gnt_q] = 1'b1;
            end
            READ, READ_CAP: begin
                ram_cs = 1'b1;
                ram_oe = 1'b1;
            end
            RESP:    ack[gnt_q] = 1'b1;
            default: ;
        endcase
    end

    assign ram_addr = addr_q;
    assign rdata    = rdata_q;
    // ram_we and ram_oe are mutually exclusive, so the RAM and this block
    // never drive the bus in the same cycle.
    assign ram_data = (state_q == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

    // op_q is kept for visibility of the latched op; the FSM path already
    // encodes it, so tie it into a harmless reduction to keep it observed.
    logic op_unused;
    assign op_unused = op_q & 1'b0;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// tb/tb_ram_sp_arbiter.sv - self-checking bench for ram_sp_arbiter
module tb_ram_sp_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef RAM_SP_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   ram_addr;
    logic            ram_cs, ram_we, ram_oe;
    wire  [DW-1:0]   ram_data;

    int checks = 0;
    int errors = 0;

    // Expected RAM contents and the arbiter's "served last" memory.
    logic [DW-1:0] model_mem [DEPTH];
    logic          m_last;

    always #5 clk = ~clk;

    ram_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_data  (ram_data)
    );

    // Single-port RAM: synchronous write, registered read, output on oe.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_dout;
    always @(posedge clk) begin
        if (ram_cs && ram_we)       ram_mem[ram_addr] <= ram_data;
        else if (ram_cs && !ram_we) ram_dout <= ram_mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_dout : {DW{1'bz}};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = 1'b1;
        req_we[i]           = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    function automatic logic tie_winner(input logic last);
        return FIXED ? 1'b0 : ~last;
    endfunction

    // One operation from a lone requester; checks pins, latency and data.
    task automatic run_op(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string tag);
        int         lat;
        bit         got;
        logic [1:0] exp_ack;
        exp_ack = 2'b01 << i;
        @(negedge clk);
        set_req(i, we, a, d);
        got = 0;
        lat = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            check({tag, "_oe_we_excl"}, {63'd0, ram_oe & ram_we}, 64'd0);
            if (ack != 2'b00) got = 1;
            else if (!we) begin
                check({tag, "_rd_cs"}, {63'd0, ram_cs}, 64'd1);
                check({tag, "_rd_oe"}, {63'd0, ram_oe}, 64'd1);
                if (lat == 2) check({tag, "_rd_bus"}, {32'd0, ram_data}, {32'd0, model_mem[a]});
            end
        end
        check({tag, "_ack"}, {62'd0, ack}, {62'd0, exp_ack});
        check({tag, "_lat"}, 64'(lat), we ? 64'd1 : 64'd3);
        if (we) begin
            check({tag, "_wr_cs_we"}, {62'd0, ram_cs, ram_we}, 64'd3);
            check({tag, "_wr_bus"}, {32'd0, ram_data}, {32'd0, d});
            model_mem[a] = d;
        end else begin
            check({tag, "_rdata"}, {32'd0, rdata}, {32'd0, model_mem[a]});
        end
        m_last = i[0];
        req[i] = 1'b0;
    endtask

    // Both requesters write in the same cycle; checks who is served first.
    task automatic run_pair(input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input logic [AW-1:0] a1, input logic [DW-1:0] d1, input string tag);
        int   order[$];
        int   guard;
        logic first;
        first = tie_winner(m_last);
        @(negedge clk);
        set_req(0, 1'b1, a0, d0);
        set_req(1, 1'b1, a1, d1);
        guard = 0;
        while (order.size() < 2 && guard < 20) begin
            @(negedge clk);
            guard++;
            check({tag, "_ack_onehot"}, {63'd0, &ack}, 64'd0);
            if (ack[0]) begin order.push_back(0); model_mem[a0] = d0; req[0] = 1'b0; end
            if (ack[1]) begin order.push_back(1); model_mem[a1] = d1; req[1] = 1'b0; end
        end
        check({tag, "_count"}, 64'(order.size()), 64'd2);
        if (order.size() == 2) begin
            check({tag, "_first"}, 64'(order[0]), {63'd0, first});
            check({tag, "_second"}, 64'(order[1]), {63'd0, ~first});
        end
        m_last = ~first;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
    endtask

    initial begin
        logic          cur_we [2];
        logic [AW-1:0] cur_a  [2];
        logic [DW-1:0] cur_d  [2];
        int            k, prev_ack, nacks, id;
        logic          exp_id;

        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_last    = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (3) @(negedge clk);

        check("rst_ack", {62'd0, ack}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        check("rst_ctl", {61'd0, ram_cs, ram_we, ram_oe}, 64'd0);
        check("rst_addr", {60'd0, ram_addr}, 64'd0);
        rst = 1'b0;

        run_op(0, 1'b1, 4'd3, 32'hDEADBEEF, "wr0_a3");
        run_op(1, 1'b0, 4'd3, 32'h0, "rd1_a3");

        do_reset();
        run_pair(4'd5, 32'h11, 4'd6, 32'h22, "pair1");
        run_op(0, 1'b0, 4'd5, 32'h0, "rd0_a5");
        run_pair(4'd5, 32'h33, 4'd6, 32'h44, "pair2");

        for (int a = 0; a < DEPTH; a++)
            run_op(a % 2, 1'b1, 4'(a), 32'(a) * 32'h01010101, "fill");
        for (int a = 0; a < DEPTH; a++)
            run_op((a + 1) % 2, 1'b0, 4'(a), 32'h0, "readback");

        // Reset while the read of addr 7 is in READ_CAP.
        @(negedge clk);
        set_req(0, 1'b0, 4'd7, 32'h0);
        @(negedge clk);
        check("mid_read_oe", {63'd0, ram_oe}, 64'd1);
        @(negedge clk);
        check("mid_cap_oe", {63'd0, ram_oe}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ack", {62'd0, ack}, 64'd0);
        check("mid_rst_ctl", {61'd0, ram_cs, ram_we, ram_oe}, 64'd0);
        rst    = 1'b0;
        req    = '0;
        m_last = 1'b1;
        @(negedge clk);
        check("post_rst_ack", {62'd0, ack}, 64'd0);
        run_op(1, 1'b0, 4'd7, 32'h0, "rd_a7_after_rst");

        // Both requesters always pending, each re-requesting at its ack.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            cur_we[i] = 1'($urandom_range(0, 1));
            cur_a[i]  = 4'($urandom_range(0, DEPTH - 1));
            cur_d[i]  = $urandom;
            set_req(i, cur_we[i], cur_a[i], cur_d[i]);
        end
        k        = 0;
        prev_ack = -1;
        nacks    = 0;
        while (nacks < 60 && k < 600) begin
            @(negedge clk);
            k++;
            check("rnd_oe_we_excl", {63'd0, ram_oe & ram_we}, 64'd0);
            if (ack != 2'b00) begin
                check("rnd_ack_onehot", {63'd0, &ack}, 64'd0);
                id     = ack[1] ? 1 : 0;
                exp_id = tie_winner(m_last);
                check("rnd_grant", 64'(id), {63'd0, exp_id});
                check("rnd_gap", 64'(k - prev_ack), cur_we[id] ? 64'd2 : 64'd4);
                if (cur_we[id]) begin
                    check("rnd_wr_bus", {32'd0, ram_data}, {32'd0, cur_d[id]});
                    model_mem[cur_a[id]] = cur_d[id];
                end else begin
                    check("rnd_rdata", {32'd0, rdata}, {32'd0, model_mem[cur_a[id]]});
                end
                m_last   = id[0];
                prev_ack = k;
                nacks++;
                cur_we[id] = 1'($urandom_range(0, 1));
                cur_a[id]  = 4'($urandom_range(0, DEPTH - 1));
                cur_d[id]  = $urandom;
                set_req(id, cur_we[id], cur_a[id], cur_d[id]);
            end
        end
        check("rnd_ack_count", 64'(nacks), 64'd60);
        req = '0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
